// File: rtl/seven_segment_scanner.sv
// Time-multiplexed driver for a BCD mm:ss seven-segment display. The digit
// values are latched once per frame, and each slot opens with an all-off guard.
module seven_segment_scanner #(
  parameter int NUMBER_OF_DIGITS            = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT    = 4,
  parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int DIGIT_RATE_IN_HZ            = 1000,
  parameter int GUARD_CYCLES                = 1000,
  parameter int BLANK_LEADING_ZERO          = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] number,
  output logic [6:0]                                           segments,
  output logic                                                 dp,
  output logic [NUMBER_OF_DIGITS-1:0]                          anodes
);

  localparam int DIVIDE     = BOARD_CLOCK_FREQUENCY_IN_HZ / DIGIT_RATE_IN_HZ;
  localparam int PW         = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam int IW         = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
  localparam int BW         = NUMBER_OF_BITS_PER_DIGIT;
  localparam int LEAD_DIGIT = 3;
  localparam int DP_DIGIT   = 2;

  logic [PW-1:0]                  prescaler;
  logic [IW-1:0]                  index;
  logic [NUMBER_OF_DIGITS*BW-1:0] snapshot;
  logic                           slot_tick;
  logic                           frame_tick;

  assign slot_tick  = (prescaler == PW'(DIVIDE - 1));
  assign frame_tick = slot_tick && (index == IW'(NUMBER_OF_DIGITS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain prescaler into index in one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      index     <= '0;
      snapshot  <= '0;
    end else begin
      prescaler <= slot_tick ? '0 : prescaler + PW'(1);
      if (slot_tick) index <= frame_tick ? '0 : index + IW'(1);
      // Latching only at the frame boundary keeps a whole frame self-consistent.
      if (frame_tick) snapshot <= number;
    end
  end

  logic [BW-1:0]               digit_value;
  logic [6:0]                  lit;
  logic                        guard;
  logic                        blank;
  logic [6:0]                  segments_next;
  logic                        dp_next;
  logic [NUMBER_OF_DIGITS-1:0] anodes_next;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    digit_value   = snapshot[int'(index)*BW +: BW];
    lit           = 7'b100_0000;
    guard         = int'(prescaler) < GUARD_CYCLES;
    blank         = (BLANK_LEADING_ZERO != 0) && (int'(index) == LEAD_DIGIT) &&
                    (digit_value == '0);
    segments_next = 7'h7F;
    dp_next       = 1'b1;
    anodes_next   = '1;

    // Lit pattern, active-high, bit0 = a ... bit6 = g; non-BCD falls to a dash.
    case (int'(digit_value))
      0:       lit = 7'b011_1111;
      1:       lit = 7'b000_0110;
      2:       lit = 7'b101_1011;
      3:       lit = 7'b100_1111;
      4:       lit = 7'b110_0110;
      5:       lit = 7'b110_1101;
      6:       lit = 7'b111_1101;
      7:       lit = 7'b000_0111;
      8:       lit = 7'b111_1111;
      9:       lit = 7'b110_1111;
      default: lit = 7'b100_0000;
    endcase

    if (!guard) begin
      anodes_next   = ~(NUMBER_OF_DIGITS'(1) << index);
      segments_next = blank ? 7'h7F : ~lit;
      dp_next       = !(int'(index) == DP_DIGIT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      segments <= 7'h7F;
      dp       <= 1'b1;
      anodes   <= '1;
    end else begin
      segments <= segments_next;
      dp       <= dp_next;
      anodes   <= anodes_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner at DIVIDE=4, GUARD_CYCLES=1:
// each slot is one all-off cycle followed by three lit cycles.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] number = 16'h0000;
  logic [6:0]  segments, segments_nb;
  logic        dp, dp_nb;
  logic [3:0]  anodes, anodes_nb;

  int vectors    = 0;
  int miscompares = 0;
  int n          = 0;   // rising edges since reset release

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4),
    .BOARD_CLOCK_FREQUENCY_IN_HZ(40), .DIGIT_RATE_IN_HZ(10),
    .GUARD_CYCLES(1), .BLANK_LEADING_ZERO(1)
  ) dut (
    .clk(clk), .rst(rst), .number(number),
    .segments(segments), .dp(dp), .anodes(anodes)
  );

  seven_segment_scanner #(
    .NUMBER_OF_DIGITS(4), .NUMBER_OF_BITS_PER_DIGIT(4),
    .BOARD_CLOCK_FREQUENCY_IN_HZ(40), .DIGIT_RATE_IN_HZ(10),
    .GUARD_CYCLES(1), .BLANK_LEADING_ZERO(0)
  ) dut_nb (
    .clk(clk), .rst(rst), .number(number),
    .segments(segments_nb), .dp(dp_nb), .anodes(anodes_nb)
  );

  // Outputs seen after edge n reflect state s = n-1: prescaler s%4, index (s/4)%4.
  function automatic logic [3:0] exp_anodes(int s);
    if (s % 4 == 0) return 4'b1111;
    return ~(4'b0001 << ((s / 4) % 4));
  endfunction

  function automatic logic exp_dp(int s);
    return !((s % 4 != 0) && ((s / 4) % 4 == 2));
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
  endtask

  task automatic test_reset();
    number = 16'h1234;
    do_reset();
    repeat (26) step();
    vectors += 2;
    if (anodes !== 4'b1011) begin miscompares++; $display("FAIL pre_reset_anodes: got %b expected 1011", anodes); end
    if (dp !== 1'b0) begin miscompares++; $display("FAIL pre_reset_dp: got %b expected 0", dp); end
    rst = 1'b0;
    #1;
    vectors += 6;
    if (anodes !== 4'b1111) begin miscompares++; $display("FAIL async_reset_anodes: got %b expected 1111", anodes); end
    if (segments !== 7'h7F) begin miscompares++; $display("FAIL async_reset_segments: got %h expected 7f", segments); end
    if (dp !== 1'b1) begin miscompares++; $display("FAIL async_reset_dp: got %b expected 1", dp); end
    if (dut.snapshot !== 16'h0000) begin miscompares++; $display("FAIL async_reset_snapshot: got %h expected 0000", dut.snapshot); end
    if (dut.prescaler !== 2'd0) begin miscompares++; $display("FAIL async_reset_prescaler: got %0d expected 0", dut.prescaler); end
    if (dut.index !== 2'd0) begin miscompares++; $display("FAIL async_reset_index: got %0d expected 0", dut.index); end
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    step();
    vectors += 2;
    if (dut.prescaler !== 2'd1) begin miscompares++; $display("FAIL first_edge_prescaler: got %0d expected 1", dut.prescaler); end
    if (anodes !== 4'b1111) begin miscompares++; $display("FAIL first_edge_anodes: got %b expected 1111", anodes); end
    step();
    vectors++;
    if (anodes !== 4'b1110) begin miscompares++; $display("FAIL second_edge_anodes: got %b expected 1110", anodes); end
  endtask

  task automatic test_scan();
    logic [6:0] tab [8];
    logic [6:0] es;
    int s;
    // frame 0 shows the reset snapshot 0000 (digit 3 blanked), frame 1 shows 1234
    tab = '{7'h40, 7'h40, 7'h40, 7'h7F, 7'h19, 7'h30, 7'h24, 7'h79};
    number = 16'h1234;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step();
      s  = n - 1;
      es = (s % 4 == 0) ? 7'h7F : tab[s / 4];
      vectors += 3;
      if (anodes !== exp_anodes(s)) begin miscompares++; $display("FAIL scan_anodes n=%0d: got %b expected %b", n, anodes, exp_anodes(s)); end
      if (segments !== es) begin miscompares++; $display("FAIL scan_segments n=%0d: got %h expected %h", n, segments, es); end
      if (dp !== exp_dp(s)) begin miscompares++; $display("FAIL scan_dp n=%0d: got %b expected %b", n, dp, exp_dp(s)); end
    end
  endtask

  task automatic test_anti_tear();
    logic [6:0] tab [12];
    logic [6:0] es;
    int s;
    tab = '{7'h40, 7'h40, 7'h40, 7'h7F,
            7'h10, 7'h12, 7'h40, 7'h7F,
            7'h40, 7'h40, 7'h79, 7'h7F};
    number = 16'h0059;
    do_reset();
    for (int k = 0; k < 48; k++) begin
      step();
      if (n == 21) number = 16'h0100;   // mid index 1 of the 0059 frame
      s  = n - 1;
      es = (s % 4 == 0) ? 7'h7F : tab[s / 4];
      vectors += 2;
      if (anodes !== exp_anodes(s)) begin miscompares++; $display("FAIL tear_anodes n=%0d: got %b expected %b", n, anodes, exp_anodes(s)); end
      if (segments !== es) begin miscompares++; $display("FAIL tear_segments n=%0d: got %h expected %h", n, segments, es); end
    end
  endtask

  task automatic test_coincident();
    logic [6:0] tab [8];
    logic [6:0] es;
    int s;
    tab = '{7'h40, 7'h40, 7'h40, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
    number = 16'h0000;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step();
      if (n == 15) number = 16'h4321;   // edge 16 is the snapshot tick
      if (n == 16) number = 16'h8888;   // too late for this frame
      s  = n - 1;
      es = (s % 4 == 0) ? 7'h7F : tab[s / 4];
      vectors++;
      if (segments !== es) begin miscompares++; $display("FAIL coincident_segments n=%0d: got %h expected %h", n, segments, es); end
    end
  endtask

  task automatic test_blank();
    logic [6:0] tab [4];
    logic [6:0] tab_nb [4];
    logic [6:0] es, es_nb;
    int s;
    tab    = '{7'h78, 7'h40, 7'h10, 7'h7F};
    tab_nb = '{7'h78, 7'h40, 7'h10, 7'h40};
    number = 16'h0907;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step();
      s = n - 1;
      if (s >= 16) begin
        es    = (s % 4 == 0) ? 7'h7F : tab[(s / 4) % 4];
        es_nb = (s % 4 == 0) ? 7'h7F : tab_nb[(s / 4) % 4];
        vectors += 3;
        if (anodes !== exp_anodes(s)) begin miscompares++; $display("FAIL blank_anodes n=%0d: got %b expected %b", n, anodes, exp_anodes(s)); end
        if (segments !== es) begin miscompares++; $display("FAIL blank_segments n=%0d: got %h expected %h", n, segments, es); end
        if (segments_nb !== es_nb) begin miscompares++; $display("FAIL noblank_segments n=%0d: got %h expected %h", n, segments_nb, es_nb); end
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [6:0] tab [4];
    logic [6:0] es;
    int s;
    tab = '{7'h3F, 7'h02, 7'h3F, 7'h79};   // digits A, 6, C, 1
    number = 16'h1C6A;
    do_reset();
    for (int k = 0; k < 32; k++) begin
      step();
      s = n - 1;
      if (s >= 16) begin
        es = (s % 4 == 0) ? 7'h7F : tab[(s / 4) % 4];
        vectors++;
        if (segments !== es) begin miscompares++; $display("FAIL invalid_segments n=%0d: got %h expected %h", n, segments, es); end
      end
    end
  endtask

  task automatic test_wrap();
    number = 16'h0000;
    do_reset();
    repeat (15) step();
    vectors += 2;
    if (dut.prescaler !== 2'd3) begin miscompares++; $display("FAIL wrap_pre_prescaler: got %0d expected 3", dut.prescaler); end
    if (dut.index !== 2'd3) begin miscompares++; $display("FAIL wrap_pre_index: got %0d expected 3", dut.index); end
    number = 16'h5678;
    step();
    vectors += 5;
    if (dut.prescaler !== 2'd0) begin miscompares++; $display("FAIL wrap_prescaler: got %0d expected 0", dut.prescaler); end
    if (dut.index !== 2'd0) begin miscompares++; $display("FAIL wrap_index: got %0d expected 0", dut.index); end
    if (dut.snapshot !== 16'h5678) begin miscompares++; $display("FAIL wrap_snapshot: got %h expected 5678", dut.snapshot); end
    if (anodes !== 4'b0111) begin miscompares++; $display("FAIL wrap_lag_anodes: got %b expected 0111", anodes); end
    if (segments !== 7'h7F) begin miscompares++; $display("FAIL wrap_lag_segments: got %h expected 7f", segments); end
    step();
    vectors++;
    if (anodes !== 4'b1111) begin miscompares++; $display("FAIL wrap_guard_anodes: got %b expected 1111", anodes); end
    step();
    vectors += 2;
    if (anodes !== 4'b1110) begin miscompares++; $display("FAIL wrap_digit0_anodes: got %b expected 1110", anodes); end
    if (segments !== 7'h00) begin miscompares++; $display("FAIL wrap_digit0_segments: got %h expected 00", segments); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_anti_tear();
    test_coincident();
    test_blank();
    test_invalid_bcd();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter NUMBER_OF_DIGITS, default 4, the number of multiplexed display digits.
REQ-002 SHALL have parameter NUMBER_OF_BITS_PER_DIGIT, default 4, the BCD width per digit.
REQ-003 SHALL have parameter BOARD_CLOCK_FREQUENCY_IN_HZ, default 100_000_000, the clk frequency.
REQ-004 SHALL have parameter DIGIT_RATE_IN_HZ, default 1000, the digit-slot advance rate; DIVIDE = BOARD_CLOCK_FREQUENCY_IN_HZ / DIGIT_RATE_IN_HZ, and DIVIDE SHALL be at least 2.
REQ-005 SHALL have parameter GUARD_CYCLES, default 1000, the anode-off cycles at the start of each slot; GUARD_CYCLES SHALL be less than DIVIDE.
REQ-006 SHALL have parameter BLANK_LEADING_ZERO, default 1, which enables blanking of digit 3 when its value is 0.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-009 SHALL have port number, input, NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT bits: BCD mm:ss. Digit 0 is [3:0] (seconds ones); digit 3 is [15:12] (minutes tens).
REQ-010 SHALL have port segments, output, 7 bits, active-low: bit0 = a through bit6 = g.
REQ-011 SHALL have port dp, output, 1 bit, active-low: decimal point used as the mm:ss separator.
REQ-012 SHALL have port anodes, output, NUMBER_OF_DIGITS bits, active-low: anodes[i] selects digit i.

Function
REQ-013 SHALL have a prescaler that counts 0..DIVIDE-1 and wraps to 0; the slot tick is prescaler==DIVIDE-1.
REQ-014 SHALL hold a digit index 0..NUMBER_OF_DIGITS-1 that advances by 1 on each slot tick and wraps from NUMBER_OF_DIGITS-1 to 0.
REQ-015 SHALL load a frame snapshot register from number on the slot tick when index==NUMBER_OF_DIGITS-1; only snapshot values are displayed, so a number change never tears mid-frame.
REQ-016 SHALL drive all anodes high (off) and segments/dp high for prescaler < GUARD_CYCLES within each slot (ghost guard).
REQ-017 SHALL drive only anodes[index] low for prescaler >= GUARD_CYCLES.
REQ-018 SHALL register segments, dp and anodes with exactly one clk of latency relative to the prescaler/index/snapshot state.
REQ-019 SHALL decode lit segments as follows:
- 0 = abcdef
- 1 = bc
- 2 = abdeg
- 3 = abcdg
- 4 = bcfg
- 5 = acdfg
- 6 = acdefg
- 7 = abc
- 8 = abcdefg
- 9 = abcdfg
REQ-020 SHALL show a non-BCD digit value (10..15) as g only (dash).
REQ-021 SHALL drive all segments high (off) for digit 3 when BLANK_LEADING_ZERO=1 and the snapshot digit 3 is 0; anodes[3] SHALL still be scanned.
REQ-022 SHALL drive dp low only while digit 2 is active; dp SHALL be high at all other times.
REQ-023 SHALL give number changes between snapshots no visible effect until the next frame boundary.
REQ-024 SHALL treat a number change coincident with the snapshot tick as sampled on that edge.

Reset
REQ-025 SHALL, on rst low, immediately (asynchronously) set prescaler=0, index=0, snapshot=0, anodes=all 1, segments=7'h7F, dp=1.
REQ-026 SHALL, after rst rises, have the first rising edge count prescaler 0->1; anodes SHALL stay all high until the prescaler reaches GUARD_CYCLES, plus 1 cycle of latency.
REQ-027 SHALL, on rst assertion mid-slot or mid-frame, abandon the slot with no partial snapshot update.

Verification (bench: BOARD_CLOCK_FREQUENCY_IN_HZ=40, DIGIT_RATE_IN_HZ=10 -> DIVIDE=4; GUARD_CYCLES=1)
REQ-028 SHALL cover reset: assert rst=0 mid-slot -> anodes=4'b1111, segments=7'h7F, dp=1 in the same cycle with no clk edge.
REQ-029 SHALL cover the scan sequence: number=16'h1234, run 2 frames -> per slot, 1 cycle all-off, then 3 cycles of anodes 1110/1101/1011/0111 in order, with segments showing 4, 3, 2, 1 (second frame) and dp low only with anodes=1011.
REQ-030 SHALL cover the anti-tear path: number changes 16'h0059 -> 16'h0100 during index 1 -> the remaining digits of the current frame show the 0059 values; 0100 appears from the next index 0.
REQ-031 SHALL cover blanking: number=16'h0907, BLANK_LEADING_ZERO=1 -> digit 3 segments=7'h7F with anodes=0111; with BLANK_LEADING_ZERO=0 -> digit 3 segments show 0 (7'b1000000).
REQ-032 SHALL cover invalid BCD: digit value 4'hC -> segments=7'b0111111 (g only).
REQ-033 SHALL cover wrap: index 3 at prescaler=3 -> next cycle index=0, prescaler=0, snapshot reloaded; outputs follow one cycle later.
